rtp_depacketizer: RTL and testbench

// Receive-side counterpart of the RTP transmit engine: parses an incoming RTP/RFC4175 packet stream
// (32-bit AXI-Stream, one packet per tlast) into the RTP header and the payload header, validates it,
// and forwards the video payload words downstream with line/offset/frame side-band information.

---
 rtl/rtp_depacketizer.sv | 238 +++++++++++++++++++++++
 tb/tb_rtp_depacketizer.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtp_depacketizer.sv
// RTP / RFC4175 receive depacketizer.
// Parses a 32-bit AXI-Stream RTP packet (6 fixed header words, then payload), validates the
// header and forwards payload words with zero latency, together with per-packet side-band info.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   s_axis_t{data,valid,ready,last}  packet input (one packet per tlast)
//   m_axis_t{data,valid,ready,last,user}  payload output, tuser = start of frame
//   line_num, pix_offset, field_id, marker, timestamp  side-band of current packet
//   pkt_info_valid                 1-cycle pulse when side-band updates
//   seq_err, len_err               1-cycle error pulses
//   drop_cnt, seq_err_cnt          saturating event counters
module rtp_depacketizer #(
    parameter logic [6:0]  PAYLOAD_TYPE = 7'd96,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    output logic [31:0]          m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tuser,
    output logic [14:0]          line_num,
    output logic [14:0]          pix_offset,
    output logic                 field_id,
    output logic                 marker,
    output logic [31:0]          timestamp,
    output logic                 pkt_info_valid,
    output logic                 seq_err,
    output logic                 len_err,
    output logic [CNT_WIDTH-1:0] drop_cnt,
    output logic [CNT_WIDTH-1:0] seq_err_cnt
);

    typedef enum logic [2:0] {
        IdleRecv,
        HeaderRecv,
        PdHeaderRecv,
        PayloadRecv,
        DropRecv
    } state_e;

    state_e         state_q, state_d;
    logic [2:0]     hdr_cnt_q, hdr_cnt_d;

    // Header fields captured before the packet is known to be valid
    logic [15:0]    seq_lo_q;
    logic           m_hdr_q;
    logic [31:0]    ts_hdr_q;
    logic [15:0]    ext_hdr_q;
    logic [15:0]    len_q;

    // Side-band and status registers
    logic [14:0]    line_q, off_q;
    logic           field_q, marker_q;
    logic [31:0]    ts_q;
    logic           pkt_info_valid_q, seq_err_q, len_err_q;
    logic [CNT_WIDTH-1:0] drop_cnt_q, seq_err_cnt_q;
    logic [31:0]    prev_ext_q;
    logic           have_prev_q;
    logic           first_beat_q;
    logic [15:0]    beat_cnt_q;

    logic           fire;
    logic           w0_bad;
    logic           drop_inc, load_w0, load_w1, load_w4, accept_pkt, pay_beat;
    logic           in_pay;
    logic [31:0]    ext_now;
    logic           seq_bad;
    logic [15:0]    beat_next;

    assign in_pay = (state_q == PayloadRecv);
    assign s_axis_tready = in_pay ? m_axis_tready : 1'b1;
    assign fire = s_axis_tvalid && s_axis_tready;

    assign w0_bad = (s_axis_tdata[31:30] != 2'd2) || s_axis_tdata[28] ||
                    (s_axis_tdata[27:24] != 4'd1) || (s_axis_tdata[22:16] != PAYLOAD_TYPE);

    always_comb begin
        state_d    = state_q;
        hdr_cnt_d  = hdr_cnt_q;
        drop_inc   = 1'b0;
        load_w0    = 1'b0;
        load_w1    = 1'b0;
        load_w4    = 1'b0;
        accept_pkt = 1'b0;
        pay_beat   = 1'b0;
        unique case (state_q)
            IdleRecv: begin
                if (fire) begin
                    if (w0_bad || s_axis_tlast) begin
                        drop_inc = 1'b1;
                        state_d  = s_axis_tlast ? IdleRecv : DropRecv;
                    end else begin
                        load_w0   = 1'b1;
                        hdr_cnt_d = 3'd1;
                        state_d   = HeaderRecv;
                    end
                end
            end
            HeaderRecv: begin
                if (fire) begin
                    if (s_axis_tlast) begin
                        drop_inc = 1'b1;
                        state_d  = IdleRecv;
                    end else begin
                        load_w1   = (hdr_cnt_q == 3'd1);
                        hdr_cnt_d = hdr_cnt_q + 3'd1;
                        if (hdr_cnt_q == 3'd3) state_d = PdHeaderRecv;
                    end
                end
            end
            PdHeaderRecv: begin
                if (fire) begin
                    if (hdr_cnt_q == 3'd4) begin
                        if (s_axis_tlast) begin
                            drop_inc = 1'b1;
                            state_d  = IdleRecv;
                        end else begin
                            load_w4   = 1'b1;
                            hdr_cnt_d = 3'd5;
                        end
                    end else if (s_axis_tdata[15]) begin
                        // Multi-line packets are not supported
                        drop_inc = 1'b1;
                        state_d  = s_axis_tlast ? IdleRecv : DropRecv;
                    end else begin
                        // tlast here is a valid zero-byte payload packet
                        accept_pkt = 1'b1;
                        state_d    = s_axis_tlast ? IdleRecv : PayloadRecv;
                    end
                end
            end
            PayloadRecv: begin
                if (fire) begin
                    pay_beat = 1'b1;
                    if (s_axis_tlast) state_d = IdleRecv;
                end
            end
            DropRecv: begin
                if (fire && s_axis_tlast) state_d = IdleRecv;
            end
            default: state_d = IdleRecv;
        endcase
    end

    assign ext_now   = {ext_hdr_q, seq_lo_q};
    assign seq_bad   = have_prev_q && (ext_now != prev_ext_q + 32'd1);
    assign beat_next = beat_cnt_q + 16'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IdleRecv;
            hdr_cnt_q        <= 3'd0;
            seq_lo_q         <= 16'd0;
            m_hdr_q          <= 1'b0;
            ts_hdr_q         <= 32'd0;
            ext_hdr_q        <= 16'd0;
            len_q            <= 16'd0;
            line_q           <= 15'd0;
            off_q            <= 15'd0;
            field_q          <= 1'b0;
            marker_q         <= 1'b0;
            ts_q             <= 32'd0;
            pkt_info_valid_q <= 1'b0;
            seq_err_q        <= 1'b0;
            len_err_q        <= 1'b0;
            drop_cnt_q       <= '0;
            seq_err_cnt_q    <= '0;
            prev_ext_q       <= 32'd0;
            have_prev_q      <= 1'b0;
            first_beat_q     <= 1'b0;
            beat_cnt_q       <= 16'd0;
        end else begin
            state_q          <= state_d;
            hdr_cnt_q        <= hdr_cnt_d;
            pkt_info_valid_q <= 1'b0;
            seq_err_q        <= 1'b0;
            len_err_q        <= 1'b0;

            if (load_w0) begin
                seq_lo_q <= s_axis_tdata[15:0];
                m_hdr_q  <= s_axis_tdata[23];
            end
            if (load_w1) ts_hdr_q <= s_axis_tdata;
            if (load_w4) begin
                ext_hdr_q <= s_axis_tdata[31:16];
                len_q     <= s_axis_tdata[15:0];
            end

            if (drop_inc && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 1'b1;

            if (accept_pkt) begin
                field_q          <= s_axis_tdata[31];
                line_q           <= s_axis_tdata[30:16];
                off_q            <= s_axis_tdata[14:0];
                marker_q         <= m_hdr_q;
                ts_q             <= ts_hdr_q;
                pkt_info_valid_q <= 1'b1;
                seq_err_q        <= seq_bad;
                if (seq_bad && (seq_err_cnt_q != '1)) seq_err_cnt_q <= seq_err_cnt_q + 1'b1;
                prev_ext_q       <= ext_now;
                have_prev_q      <= 1'b1;
                first_beat_q     <= 1'b1;
                beat_cnt_q       <= 16'd0;
                if (s_axis_tlast) len_err_q <= (len_q != 16'd0);
            end

            if (pay_beat) begin
                beat_cnt_q   <= beat_next;
                first_beat_q <= 1'b0;
                if (s_axis_tlast) len_err_q <= ({beat_next, 2'b00} != {2'b00, len_q});
            end
        end
    end

    assign m_axis_tvalid  = in_pay && s_axis_tvalid;
    assign m_axis_tdata   = in_pay ? s_axis_tdata : 32'd0;
    assign m_axis_tlast   = in_pay && s_axis_tlast;
    assign m_axis_tuser   = m_axis_tvalid && first_beat_q && (line_q == 15'd0) && (off_q == 15'd0);

    assign line_num       = line_q;
    assign pix_offset     = off_q;
    assign field_id       = field_q;
    assign marker         = marker_q;
    assign timestamp      = ts_q;
    assign pkt_info_valid = pkt_info_valid_q;
    assign seq_err        = seq_err_q;
    assign len_err        = len_err_q;
    assign drop_cnt       = drop_cnt_q;
    assign seq_err_cnt    = seq_err_cnt_q;

endmodule

// File: tb/tb_rtp_depacketizer.sv
// Randomized scoreboard bench for rtp_depacketizer.
module tb_rtp_depacketizer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic [14:0] line_num, pix_offset;
    logic        field_id, marker;
    logic [31:0] timestamp;
    logic        pkt_info_valid, seq_err, len_err;
    logic [15:0] drop_cnt, seq_err_cnt;

    always #5 clk = ~clk;

    rtp_depacketizer #(.PAYLOAD_TYPE(7'd96), .CNT_WIDTH(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tlast   (s_axis_tlast),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tuser   (m_axis_tuser),
        .line_num       (line_num),
        .pix_offset     (pix_offset),
        .field_id       (field_id),
        .marker         (marker),
        .timestamp      (timestamp),
        .pkt_info_valid (pkt_info_valid),
        .seq_err        (seq_err),
        .len_err        (len_err),
        .drop_cnt       (drop_cnt),
        .seq_err_cnt    (seq_err_cnt)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        user;
    } beat_t;

    typedef struct {
        logic [14:0] line;
        logic [14:0] off;
        logic        f;
        logic        m;
        logic [31:0] ts;
        logic        serr;
    } info_t;

    typedef struct {
        logic [1:0]  v;
        logic        x;
        logic [3:0]  cc;
        logic        m;
        logic [6:0]  pt;
        logic [31:0] ext;
        logic [31:0] ts;
        logic [15:0] len;
        logic        f;
        logic [14:0] line;
        logic        c;
        logic [14:0] off;
        int          npay;
        int          trunc;   // word index carrying tlast, -1 = natural end
        int          abort;   // payload beats sent before reset, -1 = no abort
    } pkt_t;

    beat_t exp_beats[$];
    info_t exp_info[$];

    int checks = 0;
    int errors = 0;
    int exp_drop = 0, exp_serr = 0, exp_len_err = 0, len_err_seen = 0;
    logic        have_prev = 1'b0;
    logic [31:0] prev_ext = 32'd0;
    int  rdy_mode = 0;
    bit  tog = 1'b0;
    bit  in_drop_pkt = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an output
    always @(negedge clk) begin
        #2;
        if (!reset) begin
            if (m_axis_tvalid) check("s_ready_mirror", s_axis_tready, m_axis_tready);
            if (in_drop_pkt) begin
                check("drop_tready", s_axis_tready, 1'b1);
                check("drop_no_beat", m_axis_tvalid, 1'b0);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_beats.size() == 0) begin
                    check("unexpected_beat", 1'b1, 1'b0);
                end else begin
                    beat_t b;
                    b = exp_beats.pop_front();
                    check("beat_data", m_axis_tdata, b.data);
                    check("beat_last_user", {m_axis_tlast, m_axis_tuser}, {b.last, b.user});
                end
            end
            if (pkt_info_valid) begin
                if (exp_info.size() == 0) begin
                    check("unexpected_info", 1'b1, 1'b0);
                end else begin
                    info_t e;
                    e = exp_info.pop_front();
                    check("info_line_off", {line_num, pix_offset}, {e.line, e.off});
                    check("info_f_m", {field_id, marker}, {e.f, e.m});
                    check("info_ts", timestamp, e.ts);
                    check("info_seq_err", seq_err, e.serr);
                end
            end else if (seq_err) begin
                check("stray_seq_err", 1'b1, 1'b0);
            end
            if (len_err) len_err_seen++;
        end
    end

    task automatic drive_cycle(input logic v, input logic [31:0] d, input logic l, output bit fired);
        @(negedge clk);
        case (rdy_mode)
            0: m_axis_tready = 1'b1;
            1: begin tog = ~tog; m_axis_tready = tog; end
            default: m_axis_tready = ($urandom_range(0, 2) != 0);
        endcase
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        #1;
        fired = v && s_axis_tready;
    endtask

    task automatic idle(input int n);
        bit f;
        for (int i = 0; i < n; i++) drive_cycle(1'b0, $urandom, 1'b0, f);
    endtask

    task automatic send_words(input logic [31:0] w[$], input bit mark_last);
        bit f;
        for (int i = 0; i < w.size(); i++) begin
            int tries;
            if ($urandom_range(0, 3) == 0) idle(1);
            tries = 0;
            f = 1'b0;
            while (!f) begin
                drive_cycle(1'b1, w[i], mark_last && (i == w.size() - 1), f);
                tries++;
                if (tries > 200) begin
                    $display("FAIL handshake_timeout: got stalled expected accept");
                    $fatal(1, "input handshake timeout");
                end
            end
        end
        idle(1);
    endtask

    // Reference model: decides the fate of the packet from the header rules and queues expectations
    task automatic send_pkt(input pkt_t p);
        logic [31:0] w[$];
        int last_idx, np;
        bit valid;
        w.push_back({p.v, 1'b0, p.x, p.cc, p.m, p.pt, p.ext[15:0]});
        w.push_back(p.ts);
        w.push_back($urandom);
        w.push_back($urandom);
        w.push_back({p.ext[31:16], p.len});
        w.push_back({p.f, p.line, p.c, p.off});
        for (int i = 0; i < p.npay; i++) w.push_back($urandom);
        last_idx = (p.trunc >= 0) ? p.trunc : w.size() - 1;
        if (p.abort >= 0) last_idx = 5 + p.abort;
        while (w.size() > last_idx + 1) void'(w.pop_back());

        valid = (p.v == 2'd2) && !p.x && (p.cc == 4'd1) && (p.pt == 7'd96) &&
                (last_idx >= 5) && !p.c;
        if (!valid) begin
            exp_drop++;
            in_drop_pkt = 1'b1;
        end else begin
            info_t e;
            e.line = p.line; e.off = p.off; e.f = p.f; e.m = p.m; e.ts = p.ts;
            e.serr = have_prev && (p.ext != prev_ext + 32'd1);
            exp_serr += int'(e.serr);
            prev_ext = p.ext;
            have_prev = 1'b1;
            exp_info.push_back(e);
            np = last_idx - 5;
            for (int i = 0; i < np; i++) begin
                beat_t b;
                b.data = w[6 + i];
                b.last = (p.abort < 0) && (i == np - 1);
                b.user = (i == 0) && (p.line == 15'd0) && (p.off == 15'd0);
                exp_beats.push_back(b);
            end
            if (p.abort < 0 && np * 4 != int'(p.len)) exp_len_err++;
        end
        send_words(w, p.abort < 0);
        in_drop_pkt = 1'b0;
    endtask

    function automatic pkt_t good_pkt(input logic [31:0] ext, input logic [14:0] line,
                                      input logic [14:0] off, input int npay);
        pkt_t p;
        p.v = 2'd2; p.x = 1'b0; p.cc = 4'd1; p.m = 1'b0; p.pt = 7'd96;
        p.ext = ext; p.ts = $urandom; p.len = 16'(npay * 4);
        p.f = 1'b0; p.line = line; p.c = 1'b0; p.off = off;
        p.npay = npay; p.trunc = -1; p.abort = -1;
        return p;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        m_axis_tready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_beats.delete();
        exp_info.delete();
        have_prev = 1'b0;
        exp_drop = 0; exp_serr = 0; exp_len_err = 0; len_err_seen = 0;
        #1;
        check("rst_m_tvalid", m_axis_tvalid, 1'b0);
        check("rst_s_tready", s_axis_tready, 1'b1);
        check("rst_counters", {drop_cnt, seq_err_cnt}, 32'd0);
        check("rst_sideband", {line_num, pix_offset, timestamp, pkt_info_valid, seq_err, len_err},
              64'd0);
    endtask

    task automatic settle(input string tag);
        idle(4);
        check({tag, "_drop_cnt"}, drop_cnt, 16'(exp_drop));
        check({tag, "_seq_err_cnt"}, seq_err_cnt, 16'(exp_serr));
        check({tag, "_len_err"}, len_err_seen, exp_len_err);
        check({tag, "_sb_empty"}, exp_beats.size() + exp_info.size(), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        pkt_t p;
        logic [31:0] next_ext;
        reset = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata = 32'd0;
        s_axis_tlast = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) @(negedge clk);
        do_reset();

        // Basic valid packet, start of frame
        p = good_pkt(32'h0000_0005, 15'd0, 15'd0, 4);
        send_pkt(p);
        settle("basic");

        // Extended sequence carry is in order; a skip is an error
        do_reset();
        send_pkt(good_pkt(32'h0000_FFFF, 15'd1, 15'd0, 2));
        send_pkt(good_pkt(32'h0001_0000, 15'd2, 15'd0, 2));
        send_pkt(good_pkt(32'h0001_0002, 15'd3, 15'd0, 2));
        settle("seq");
        check("seq_err_cnt_one", seq_err_cnt, 16'd1);

        // Version 1 packet dropped, next packet fine
        p = good_pkt(32'h0001_0003, 15'd4, 15'd0, 4);
        p.v = 2'd1;
        send_pkt(p);
        send_pkt(good_pkt(32'h0001_0004, 15'd4, 15'd0, 4));
        settle("drop_v");

        // Backpressure toggling every cycle
        rdy_mode = 1;
        p = good_pkt(32'h0001_0005, 15'd5, 15'd100, 8);
        p.m = 1'b1; p.f = 1'b1;
        send_pkt(p);
        settle("toggle");
        rdy_mode = 0;

        // Length mismatch, then a packet truncated on W3
        p = good_pkt(32'h0001_0006, 15'd6, 15'd0, 4);
        p.len = 16'd20;
        send_pkt(p);
        p = good_pkt(32'h0001_0007, 15'd7, 15'd0, 4);
        p.trunc = 3;
        send_pkt(p);
        settle("len_trunc");

        // 32-bit wrap of the extended sequence is in order
        send_pkt(good_pkt(32'hFFFF_FFFF, 15'd8, 15'd0, 1));
        send_pkt(good_pkt(32'h0000_0000, 15'd9, 15'd0, 1));
        settle("wrap");

        // Randomized mix of valid and malformed packets
        rdy_mode = 2;
        next_ext = 32'h0000_0001;
        for (int n = 0; n < 40; n++) begin
            int kind;
            if ($urandom_range(0, 4) == 0) next_ext = $urandom;
            p = good_pkt(next_ext, 15'($urandom_range(0, 2)), 15'($urandom_range(0, 1)),
                         $urandom_range(1, 10));
            p.m = 1'($urandom);
            p.f = 1'($urandom);
            if ($urandom_range(0, 3) == 0) p.len = 16'($urandom_range(0, 40));
            kind = $urandom_range(0, 9);
            case (kind)
                0: p.v = 2'($urandom_range(0, 1));
                1: p.pt = 7'd97;
                2: p.c = 1'b1;
                3: p.trunc = $urandom_range(0, 4);
                4: p.trunc = 5;
                5: p.x = 1'b1;
                6: p.cc = 4'd0;
                default: ;
            endcase
            send_pkt(p);
            next_ext = next_ext + 32'd1;
        end
        settle("random");
        rdy_mode = 0;

        // Reset in the middle of a payload; the next packet is the first one again
        p = good_pkt(32'h0000_0100, 15'd0, 15'd0, 6);
        p.abort = 2;
        send_pkt(p);
        idle(2);
        do_reset();
        send_pkt(good_pkt(32'h0000_0007, 15'd0, 15'd0, 3));
        settle("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
